kb_uart_rx: RTL and testbench

Serial 8N1 receiver front end for the keyboard path. It samples the raw keyboard/terminal RX line and deserialises bytes into a small FIFO. It then presents the bytes one at a time on the write side of kb_scr_drv. Its outputs drive that driver's data_bus_i and control_i[1] (write_en), and it consumes the driver's control_o[0] (write_ok).

---
 rtl/kb_dev_pkg.sv | 30 +++
 rtl/kb_rx_fifo.sv | 61 ++++++
 rtl/kb_uart_rx.sv | 163 ++++++++++++++++
 tb/tb_kb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_dev_pkg.sv
// Shared definitions for the keyboard device slice: receive FSM states,
// CSR bit positions used by kb_scr_drv, and default baud constants.
package kb_dev_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // CSR bit indices shared with kb_scr_drv
    localparam int unsigned CSR_ENA = 4;
    localparam int unsigned CSR_OF  = 3;
    localparam int unsigned CSR_DBA = 2;
    localparam int unsigned CSR_IO  = 1;
    localparam int unsigned CSR_IE  = 0;

    // Default baud setup: 50 MHz system clock, 115200 baud
    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    localparam int unsigned DEF_CLKS_PER_BIT = clks_per_bit(DEF_CLK_HZ, DEF_BAUD);

endpackage

// File: rtl/kb_rx_fifo.sv
// Small synchronous byte FIFO. A push while full is accepted only when a pop
// frees the slot in the same cycle; otherwise it is dropped and reported.
module kb_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kb_uart_rx.sv
// 8N1 serial receiver for the keyboard path. Deserialises rx_i into a byte
// FIFO and offers bytes to kb_scr_drv through a level-based write handshake.
module kb_uart_rx
    import kb_dev_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic [7:0]                    data_bus_o,
    output logic                          write_en_o,
    input  logic                          write_ok_i,
    input  logic                          clr_err_i,
    output logic                          frame_err_o,
    output logic                          ovf_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam int unsigned CNTW = $clog2(CLKS_PER_BIT);
    localparam logic [CNTW-1:0] HALF_M1 = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTW-1:0] FULL_M1 = CNTW'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    rx_state_t              state;
    logic [CNTW-1:0]        cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   armed;
    logic                   push_q;

    logic [7:0]             fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_drop;
    logic                   fifo_pop;

    // Input synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Receive FSM: start validation, mid-bit sampling, stop check, framing flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            armed       <= 1'b1;
            push_q      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // Clear first; a framing error later in this block overrides it
            if (clr_err_i) begin
                frame_err_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (armed && !rx_s) begin
                        state <= START;
                    end else if (!armed && rx_s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            push_q <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                            armed       <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_pop = write_en_o & write_ok_i;

    // shreg holds the byte until the next frame's first data sample, so it
    // can feed the FIFO directly on the cycle after the stop sample
    kb_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (shreg),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt_o),
        .drop      (fifo_drop)
    );

    // Write handshake towards kb_scr_drv plus the sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_bus_o <= '0;
            write_en_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            if (clr_err_i) begin
                ovf_o <= 1'b0;
            end
            if (fifo_drop) begin
                ovf_o <= 1'b1;
            end
            if (!write_en_o && !fifo_empty) begin
                data_bus_o <= fifo_head;
                write_en_o <= 1'b1;
            end else if (fifo_pop) begin
                write_en_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kb_uart_rx.sv
// Self-checking bench for kb_uart_rx: directed scenarios plus random frames,
// scored against a queue model of the bytes the driver should receive.
module tb_kb_uart_rx;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    // Edges from the start-bit falling drive to the stop-bit sample:
    // synchroniser + idle detect, half a bit, then nine full bits
    localparam int unsigned STOP_EDGE = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_i;
    logic [7:0]    data_bus_o;
    logic          write_en_o;
    logic          write_ok_i;
    logic          clr_err_i;
    logic          frame_err_o;
    logic          ovf_o;
    logic [CW-1:0] fifo_cnt_o;

    logic          wen_d;
    logic          ok_auto;
    logic          ok_force;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;

    logic [7:0]    exp_q [$];
    logic          exp_ovf;

    logic          prev_pop;
    logic          prev_wen;
    logic [7:0]    prev_data;

    always #5 clk = ~clk;

    kb_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_bus_o  (data_bus_o),
        .write_en_o  (write_en_o),
        .write_ok_i  (write_ok_i),
        .clr_err_i   (clr_err_i),
        .frame_err_o (frame_err_o),
        .ovf_o       (ovf_o),
        .fifo_cnt_o  (fifo_cnt_o)
    );

    // Driver-side acknowledge: write_en delayed one cycle, or forced
    always @(posedge clk or posedge rst) begin
        if (rst) wen_d <= 1'b0;
        else     wen_d <= write_en_o;
    end
    assign write_ok_i = ok_auto ? wen_d : ok_force;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a byte reaches the FIFO if there is room, else overflow
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    // Monitor: delivered bytes in order, gap after each ack, stable data
    always @(negedge clk) begin
        if (rst) begin
            prev_pop  = 1'b0;
            prev_wen  = 1'b0;
            prev_data = '0;
        end else begin
            if (prev_pop) check("gap_after_ack", write_en_o, 0);
            else if (prev_wen && write_en_o) check("data_stable", data_bus_o, prev_data);
            if (write_en_o && write_ok_i) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("byte_value", data_bus_o, exp_q.pop_front());
            end
            prev_pop  = write_en_o && write_ok_i;
            prev_wen  = write_en_o;
            prev_data = data_bus_o;
        end
    end

    // Caller must be at a negedge; the start bit begins immediately
    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned post_low);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int unsigned i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) repeat (post_low) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_cnt_o == 0 && !write_en_o) break;
        end
        check(tag, exp_q.size(), 0);
        check({tag, "_cnt"}, fifo_cnt_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned lat;
        int unsigned cnt_lat;
        logic [7:0]  b;

        rst       = 1'b1;
        rx_i      = 1'b1;
        clr_err_i = 1'b0;
        ok_auto   = 1'b1;
        ok_force  = 1'b0;
        exp_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {data_bus_o, write_en_o, frame_err_o, ovf_o, fifo_cnt_o}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single byte, latency and handshake
        lat = 0;
        cnt_lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                for (int k = 1; k <= 200; k++) begin
                    @(posedge clk);
                    #1;
                    if (cnt_lat == 0 && fifo_cnt_o != 0) cnt_lat = k;
                    if (write_en_o) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        model_push(8'hA5);
        check("t1_push_edge", cnt_lat, STOP_EDGE + 1);
        check("t1_wen_edge", lat, STOP_EDGE + 2);
        check("t1_data", data_bus_o, 8'hA5);
        check("t1_cnt_one", fifo_cnt_o, 1);
        wait_drain("t1_drain");
        check("t1_flags", {frame_err_o, ovf_o}, 0);

        // 2: short glitch is rejected
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (100) @(negedge clk);
        check("t2_no_push", fifo_cnt_o, 0);
        check("t2_no_ferr", frame_err_o, 0);

        // 3: framing error followed by a break
        send_frame(8'h3C, 1'b0, 40);
        check("t3_ferr_set", frame_err_o, 1);
        repeat (120) @(negedge clk);
        check("t3_no_push", fifo_cnt_o, 0);
        check("t3_ferr_held", frame_err_o, 1);
        pulse_clr();
        check("t3_ferr_clr", frame_err_o, 0);
        repeat (20) @(negedge clk);

        // 3b: clear coinciding with a new framing error, set wins
        fork
            send_frame(8'h3C, 1'b0, 0);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1 clr_err_i = 1'b1;
                @(posedge clk);
                #1 clr_err_i = 1'b0;
                check("t3b_set_wins", frame_err_o, 1);
            end
        join
        repeat (20) @(negedge clk);
        pulse_clr();
        check("t3b_ferr_clr", frame_err_o, 0);

        // 4: overflow with acknowledge held off
        ok_auto  = 1'b0;
        ok_force = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, 0);
            model_push(b);
        end
        repeat (4) @(negedge clk);
        check("t4_cnt_full", fifo_cnt_o, DEPTH);
        check("t4_ovf", ovf_o, exp_ovf);
        check("t4_wen_stuck", write_en_o, 1);
        check("t4_head", data_bus_o, 8'h01);
        ok_auto = 1'b1;
        wait_drain("t4_drain");
        pulse_clr();
        exp_ovf = 1'b0;
        check("t4_ovf_clr", ovf_o, exp_ovf);

        // 5: push and pop in the same cycle while full
        ok_auto = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 * (i + 1));
            send_frame(b, 1'b1, 0);
            model_push(b);
        end
        repeat (4) @(negedge clk);
        check("t5_cnt_full", fifo_cnt_o, DEPTH);
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                repeat (STOP_EDGE) @(posedge clk);
                #1 ok_force = 1'b1;
                @(posedge clk);
                #1 ok_force = 1'b0;
                check("t5_cnt_kept", fifo_cnt_o, DEPTH);
                check("t5_no_ovf", ovf_o, 0);
            end
        join
        model_push(8'h55);
        check("t5_model_ovf", ovf_o, exp_ovf);
        ok_auto = 1'b1;
        wait_drain("t5_drain");

        // 6: asynchronous reset in the middle of a frame
        check("t6_pre_data", data_bus_o, 8'h55);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        b = 8'h7E;
        for (int unsigned i = 0; i < 3; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        #2 rst = 1'b1;
        rx_i = 1'b1;
        #1;
        check("t6_async_rst", {data_bus_o, write_en_o, frame_err_o, ovf_o, fifo_cnt_o}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h42, 1'b1, 0);
        model_push(8'h42);
        wait_drain("t6_drain");

        // Random frames with idle gaps and occasional glitches
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                rx_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rx_i = 1'b1;
                repeat (10) @(negedge clk);
            end
            send_frame(b, 1'b1, 0);
            model_push(b);
        end
        wait_drain("rnd_drain");
        check("rnd_flags", {frame_err_o, ovf_o}, {1'b0, exp_ovf});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
